// File: rtl/ex_mem_flag_reg.sv
// EX/MEM pipeline register with the architectural flag register.
// Branch conditions are evaluated on the bypassed (next-cycle) flag value.
module ex_mem_flag_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NFLAGS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W:0]   alu_res,
  input  logic [4:0]        alu_flags,
  input  logic              flag_wr_en,
  input  logic              reg_wr_en,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [DATA_W-1:0] store_data,
  input  logic [2:0]        cond_sel,
  output logic              cond_true,
  output logic              out_valid,
  output logic [DATA_W-1:0] mem_alu_res,
  output logic [REG_AW-1:0] mem_rd_addr,
  output logic              mem_reg_wr_en,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [NFLAGS-1:0] flag_reg
);

  logic              load;
  logic              flag_upd;
  logic [NFLAGS-1:0] flag_new;
  logic [NFLAGS-1:0] flag_next;
  logic              unused_flag_bit;

  assign unused_flag_bit = alu_flags[4];

  assign load     = ~stall & ~flush;
  // rst gates the bypass so conditions see the cleared flags while in reset
  assign flag_upd = ~rst & load & in_valid & flag_wr_en;
  assign flag_new = {alu_res[DATA_W], alu_flags[2] | alu_flags[0],
                     alu_flags[3], alu_flags[2], alu_flags[1], alu_flags[0]};
  assign flag_next = flag_upd ? flag_new : flag_reg;

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flag_next[0];
      3'd2:    cond_true = flag_next[1];
      3'd3:    cond_true = flag_next[2];
      3'd4:    cond_true = flag_next[3];
      3'd5:    cond_true = flag_next[4];
      3'd6:    cond_true = flag_next[5];
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      mem_alu_res    <= '0;
      mem_rd_addr    <= '0;
      mem_reg_wr_en  <= 1'b0;
      mem_rd_en_o    <= 1'b0;
      mem_wr_en_o    <= 1'b0;
      mem_store_data <= '0;
      flag_reg       <= '0;
    end else if (!stall) begin
      if (flush) begin
        out_valid     <= 1'b0;
        mem_reg_wr_en <= 1'b0;
        mem_rd_en_o   <= 1'b0;
        mem_wr_en_o   <= 1'b0;
      end else begin
        out_valid      <= in_valid;
        mem_alu_res    <= alu_res[DATA_W-1:0];
        mem_rd_addr    <= rd_addr;
        mem_reg_wr_en  <= reg_wr_en & in_valid;
        mem_rd_en_o    <= mem_rd_en & in_valid;
        mem_wr_en_o    <= mem_wr_en & in_valid;
        mem_store_data <= store_data;
      end
      flag_reg <= flag_next;
    end
  end

endmodule

// File: tb/tb_ex_mem_flag_reg.sv
// Bench for ex_mem_flag_reg: spec-level model checked every negedge,
// plus hand-computed literal expectations along a directed sequence.
module tb_ex_mem_flag_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, flush, in_valid, flag_wr_en, reg_wr_en;
  logic        mem_rd_en, mem_wr_en;
  logic [32:0] alu_res;
  logic [4:0]  alu_flags;
  logic [4:0]  rd_addr;
  logic [31:0] store_data;
  logic [2:0]  cond_sel;
  logic        cond_true, out_valid, mem_reg_wr_en, mem_rd_en_o, mem_wr_en_o;
  logic [31:0] mem_alu_res, mem_store_data;
  logic [4:0]  mem_rd_addr;
  logic [5:0]  flag_reg;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  ex_mem_flag_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_res(alu_res), .alu_flags(alu_flags), .flag_wr_en(flag_wr_en),
    .reg_wr_en(reg_wr_en), .rd_addr(rd_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .store_data(store_data), .cond_sel(cond_sel),
    .cond_true(cond_true), .out_valid(out_valid), .mem_alu_res(mem_alu_res),
    .mem_rd_addr(mem_rd_addr), .mem_reg_wr_en(mem_reg_wr_en),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_store_data(mem_store_data), .flag_reg(flag_reg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: named architectural flags and the MEM-stage contents
  bit        m_valid, m_rwe, m_mre, m_mwe, m_data_known;
  bit [31:0] m_alu, m_sd;
  bit [4:0]  m_rd;
  bit        f_zero, f_true, f_neg, f_ovf, f_nz, f_carry;

  function automatic bit do_flag_update();
    return !rst && !stall && !flush && in_valid && flag_wr_en;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0; m_rwe <= 0; m_mre <= 0; m_mwe <= 0; m_data_known <= 1;
      m_alu <= 0; m_sd <= 0; m_rd <= 0;
      f_zero <= 0; f_true <= 0; f_neg <= 0; f_ovf <= 0; f_nz <= 0; f_carry <= 0;
    end else if (!stall) begin
      if (flush) begin
        m_valid <= 0; m_rwe <= 0; m_mre <= 0; m_mwe <= 0; m_data_known <= 0;
      end else begin
        m_valid <= in_valid;
        m_rwe   <= in_valid && reg_wr_en;
        m_mre   <= in_valid && mem_rd_en;
        m_mwe   <= in_valid && mem_wr_en;
        m_alu   <= alu_res[31:0];
        m_sd    <= store_data;
        m_rd    <= rd_addr;
        m_data_known <= 1;
      end
      if (do_flag_update()) begin
        f_zero  <= alu_flags[0];
        f_true  <= alu_flags[1];
        f_neg   <= alu_flags[2];
        f_ovf   <= alu_flags[3];
        f_nz    <= alu_flags[2] || alu_flags[0];
        f_carry <= alu_res[32];
      end
    end
  end

  // Condition truth table over the flags that the next instruction will see
  function automatic bit model_cond();
    bit z, t, n, o, nz, c;
    bit [7:0] tbl;
    if (do_flag_update()) begin
      z = alu_flags[0]; t = alu_flags[1]; n = alu_flags[2]; o = alu_flags[3];
      nz = alu_flags[2] || alu_flags[0]; c = alu_res[32];
    end else begin
      z = f_zero; t = f_true; n = f_neg; o = f_ovf; nz = f_nz; c = f_carry;
    end
    tbl = {1'b0, c, nz, o, n, t, z, 1'b1};
    return tbl[cond_sel];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_out_valid", 64'(out_valid), 64'(m_valid));
      check("m_reg_wr", 64'(mem_reg_wr_en), 64'(m_rwe));
      check("m_rd_en", 64'(mem_rd_en_o), 64'(m_mre));
      check("m_wr_en", 64'(mem_wr_en_o), 64'(m_mwe));
      check("m_flags", 64'(flag_reg), 64'({f_carry, f_nz, f_ovf, f_neg, f_true, f_zero}));
      check("m_cond", 64'(cond_true), 64'(model_cond()));
      if (m_data_known) begin
        check("m_alu_res", 64'(mem_alu_res), 64'(m_alu));
        check("m_rd_addr", 64'(mem_rd_addr), 64'(m_rd));
        check("m_store", 64'(mem_store_data), 64'(m_sd));
      end
      $display("cycle t=%0t valid=%0b rd=%0d alu=%0h flags=%0h cond=%0b",
               $time, out_valid, mem_rd_addr, mem_alu_res, flag_reg, cond_true);
    end
  end

  task automatic clear_in();
    stall = 0; flush = 0; in_valid = 0; flag_wr_en = 0; reg_wr_en = 0;
    mem_rd_en = 0; mem_wr_en = 0; alu_res = '0; alu_flags = '0;
    rd_addr = '0; store_data = '0; cond_sel = '0;
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    #1 rst = 1;
    chk_on = 1;
    tick(); tick();
    #1 rst = 0;
    tick();
    check("reset_flags", 64'(flag_reg), 64'h0);
    check("reset_valid", 64'(out_valid), 64'h0);

    // Flag capture: carry and zero set, negzero follows zero
    #1 clear_in();
    in_valid = 1; flag_wr_en = 1; reg_wr_en = 1; rd_addr = 5'd4;
    alu_res = 33'h1_0000_0000; alu_flags = 5'b00001; cond_sel = 3'd6;
    #1 check("cap_cond_carry", 64'(cond_true), 64'h1);
    tick();
    check("cap_flags", 64'(flag_reg), 64'b110001);
    check("cap_alu", 64'(mem_alu_res), 64'h0);
    check("cap_valid", 64'(out_valid), 64'h1);

    // No flag update; a load in flight
    #1 clear_in();
    in_valid = 1; reg_wr_en = 1; mem_rd_en = 1; rd_addr = 5'd5;
    alu_res = 33'h0_8000_0000; alu_flags = 5'b00110; cond_sel = 3'd2;
    #1 check("noupd_cond_true", 64'(cond_true), 64'h0);
    tick();
    check("noupd_flags", 64'(flag_reg), 64'b110001);
    check("noupd_alu", 64'(mem_alu_res), 64'h8000_0000);
    check("noupd_rd_en", 64'(mem_rd_en_o), 64'h1);

    // Store with neg result
    #1 clear_in();
    in_valid = 1; mem_wr_en = 1; flag_wr_en = 1; rd_addr = 5'd7;
    store_data = 32'hDEAD_BEEF; alu_res = 33'h0_0000_0005; alu_flags = 5'b00100;
    tick();
    check("store_flags", 64'(flag_reg), 64'h14);
    check("store_wr_en", 64'(mem_wr_en_o), 64'h1);

    // Stall wins over flush: everything holds
    #1 clear_in();
    stall = 1; flush = 1; in_valid = 1; flag_wr_en = 1; reg_wr_en = 1;
    rd_addr = 5'd9; alu_res = 33'h1_FFFF_FFFF; alu_flags = 5'b01111; cond_sel = 3'd3;
    #1 check("stall_cond_neg", 64'(cond_true), 64'h1);
    tick();
    check("stall_rd", 64'(mem_rd_addr), 64'd7);
    check("stall_store", 64'(mem_store_data), 64'hDEAD_BEEF);
    check("stall_flags", 64'(flag_reg), 64'h14);
    check("stall_valid", 64'(out_valid), 64'h1);

    // Flush alone: bubble, flags hold
    #1 stall = 0; cond_sel = 3'd6;
    #1 check("flush_cond_carry", 64'(cond_true), 64'h0);
    tick();
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_reg_wr", 64'(mem_reg_wr_en), 64'h0);
    check("flush_flags", 64'(flag_reg), 64'h14);

    // Invalid instruction never writes anything
    #1 clear_in();
    reg_wr_en = 1; mem_wr_en = 1; mem_rd_en = 1; flag_wr_en = 1;
    alu_res = 33'h1_0000_0000; alu_flags = 5'b01111;
    tick();
    check("inv_valid", 64'(out_valid), 64'h0);
    check("inv_reg_wr", 64'(mem_reg_wr_en), 64'h0);
    check("inv_wr_en", 64'(mem_wr_en_o), 64'h0);
    check("inv_flags", 64'(flag_reg), 64'h14);

    // Back-to-back valid instructions
    for (int i = 1; i <= 3; i++) begin
      #1 clear_in();
      in_valid = 1; reg_wr_en = 1; rd_addr = 5'(i); cond_sel = 3'd7;
      case (i)
        1: begin flag_wr_en = 1; alu_flags = 5'b00010; alu_res = 33'h0_0000_0001; end
        2: begin flag_wr_en = 1; alu_flags = 5'b01000; alu_res = 33'h1_0000_0010; end
        default: begin flag_wr_en = 0; alu_flags = 5'b00001; alu_res = 33'h0_0000_0020; end
      endcase
      #1 check("b2b_cond_never", 64'(cond_true), 64'h0);
      tick();
      check("b2b_rd", 64'(mem_rd_addr), 64'(i));
      check("b2b_flags", 64'(flag_reg), (i == 1) ? 64'h02 : 64'h28);
    end

    // Fill all flags, then async reset mid-cycle
    #1 clear_in();
    in_valid = 1; flag_wr_en = 1; reg_wr_en = 1; rd_addr = 5'd12;
    alu_res = 33'h1_0000_0000; alu_flags = 5'b01111;
    tick();
    check("all_flags", 64'(flag_reg), 64'h3F);
    check("all_valid", 64'(out_valid), 64'h1);
    #1 clear_in();
    cond_sel = 3'd1;
    #1 rst = 1;
    #1;
    check("arst_valid", 64'(out_valid), 64'h0);
    check("arst_flags", 64'(flag_reg), 64'h0);
    check("arst_rd", 64'(mem_rd_addr), 64'h0);
    check("arst_cond_zero", 64'(cond_true), 64'h0);
    cond_sel = 3'd0;
    #1 check("arst_cond_always", 64'(cond_true), 64'h1);
    tick();
    check("arst_hold_flags", 64'(flag_reg), 64'h0);
    #1 rst = 0;
    tick(); tick();

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
